// File: rtl/pad_window_sequencer.sv
// pad_window_sequencer
//   Runs one pass of the input-padding stage and then walks non-overlapping
//   FILTER_SIZE x FILTER_SIZE windows over the PADDED x PADDED result in
//   raster order, handing top-left coordinates to the downstream engine.
//
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous active-high reset
//   start      request one pass (sampled only in IDLE)
//   abort      cancel the pass (honoured in LOAD/SETTLE/SCAN)
//   pad_en     one-cycle enable to the padding register
//   busy       high in every state except IDLE
//   win_valid  window coordinates valid (SCAN)
//   win_ready  consumer accepts the window this cycle
//   win_row    top-left row of the current window
//   win_col    top-left column of the current window
//   win_last   current window is the final one
//   done       one-cycle pulse when a pass completes normally
//
// state  | meaning
// -------+----------------------------------------------------
// IDLE   | waiting for start
// LOAD   | pad register enabled for one cycle
// SETTLE | one cycle for the padded array to become stable
// SCAN   | presenting windows with valid/ready handshake
// DONE   | one-cycle completion pulse, then back to IDLE
module pad_window_sequencer #(
    parameter int SIZE        = 5,
    parameter int FILTER_SIZE = 3,
    localparam int PADDED     = SIZE + ((FILTER_SIZE - SIZE % FILTER_SIZE) % FILTER_SIZE),
    localparam int NWIN       = PADDED / FILTER_SIZE,
    localparam int COORD_W    = (PADDED > 1) ? $clog2(PADDED) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               pad_en,
    output logic               busy,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               win_last,
    output logic               done
);

    localparam logic [COORD_W-1:0] LAST_C = COORD_W'((NWIN - 1) * FILTER_SIZE);
    localparam logic [COORD_W-1:0] STEP   = COORD_W'(FILTER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state, state_next;
    logic [COORD_W-1:0] row, col;
    logic accept;
    logic at_last;

    assign accept  = (state == S_SCAN) && win_ready;
    assign at_last = (row == LAST_C) && (col == LAST_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   state_next = abort ? S_IDLE : S_SETTLE;
            S_SETTLE: state_next = abort ? S_IDLE : S_SCAN;
            S_SCAN: begin
                // abort takes priority over completing the final window
                if (abort) begin
                    state_next = S_IDLE;
                end else if (accept && at_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Counters only hold meaning in SCAN; anything that leaves or has not
    // yet entered SCAN clears them, so each pass begins at (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (state_next != S_SCAN) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (int'(col) + FILTER_SIZE >= PADDED) begin
                col <= '0;
                row <= row + STEP;
            end else begin
                col <= col + STEP;
            end
        end
    end

    always_comb begin
        pad_en    = 1'b0;
        busy      = 1'b0;
        win_valid = 1'b0;
        win_last  = 1'b0;
        done      = 1'b0;
        case (state)
            S_LOAD:   begin pad_en = 1'b1; busy = 1'b1; end
            S_SETTLE: busy = 1'b1;
            S_SCAN:   begin busy = 1'b1; win_valid = 1'b1; win_last = at_last; end
            S_DONE:   begin busy = 1'b1; done = 1'b1; end
            default:  ;
        endcase
    end

    assign win_row = row;
    assign win_col = col;

endmodule

// File: tb/tb_pad_window_sequencer.sv
module tb_pad_window_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       win_ready = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [2:0] pad_v, busy_v, valid_v, last_v, done_v;
    logic [2:0] row0, col0, row1, col1;
    logic [1:0] row2, col2;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int base = 0;
    int pad_count0 = 0;

    typedef struct {
        int d;
        int row;
        int col;
        int last;
        int cyc;
    } win_t;

    typedef struct {
        int d;
        int cyc;
    } done_t;

    win_t  wq[$];
    done_t dq[$];

    pad_window_sequencer #(.SIZE(5), .FILTER_SIZE(3)) u5 (
        .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort),
        .pad_en(pad_v[0]), .busy(busy_v[0]), .win_valid(valid_v[0]), .win_ready(win_ready),
        .win_row(row0), .win_col(col0), .win_last(last_v[0]), .done(done_v[0])
    );

    pad_window_sequencer #(.SIZE(6), .FILTER_SIZE(3)) u6 (
        .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort),
        .pad_en(pad_v[1]), .busy(busy_v[1]), .win_valid(valid_v[1]), .win_ready(win_ready),
        .win_row(row1), .win_col(col1), .win_last(last_v[1]), .done(done_v[1])
    );

    pad_window_sequencer #(.SIZE(2), .FILTER_SIZE(3)) u2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort),
        .pad_en(pad_v[2]), .busy(busy_v[2]), .win_valid(valid_v[2]), .win_ready(win_ready),
        .win_row(row2), .win_col(col2), .win_last(last_v[2]), .done(done_v[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int row_of(int d);
        case (d)
            0: return int'(row0);
            1: return int'(row1);
            default: return int'(row2);
        endcase
    endfunction

    function automatic int col_of(int d);
        case (d)
            0: return int'(col0);
            1: return int'(col1);
            default: return int'(col2);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int d);
        check("idle_pad_en", int'(pad_v[d]), 0);
        check("idle_busy", int'(busy_v[d]), 0);
        check("idle_win_valid", int'(valid_v[d]), 0);
        check("idle_win_row", row_of(d), 0);
        check("idle_win_col", col_of(d), 0);
        check("idle_win_last", int'(last_v[d]), 0);
        check("idle_done", int'(done_v[d]), 0);
    endtask

    // Scoreboard monitor: pops an expectation on every accepted window and
    // every done pulse, comparing coordinates, last flag and cycle.
    always @(negedge clk) begin
        win_t  e;
        done_t de;
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (valid_v[d] && win_ready) begin
                    if (wq.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_window: dut %0d got (%0d,%0d), expected none", d, row_of(d), col_of(d));
                    end else begin
                        e = wq.pop_front();
                        check("win_dut", d, e.d);
                        check("win_row", row_of(d), e.row);
                        check("win_col", col_of(d), e.col);
                        check("win_last", int'(last_v[d]), e.last);
                        check("win_cycle", cyc - base, e.cyc);
                    end
                end
                if (done_v[d]) begin
                    if (dq.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done: dut %0d got done at cycle %0d, expected none", d, cyc - base);
                    end else begin
                        de = dq.pop_front();
                        check("done_dut", d, de.d);
                        check("done_cycle", cyc - base, de.cyc);
                    end
                end
            end
            if (pad_v[0]) pad_count0++;
        end
    end

    task automatic push_windows(input int d, input int first_cyc);
        int ng;
        ng = (d == 2) ? 1 : 2;
        for (int r = 0; r < ng; r++) begin
            for (int c = 0; c < ng; c++) begin
                wq.push_back('{d, r * 3, c * 3, ((r == ng - 1) && (c == ng - 1)) ? 1 : 0,
                               first_cyc + r * ng + c});
            end
        end
    endtask

    // One uninterrupted pass with win_ready held high; start at cycle 0.
    task automatic full_pass(input int d);
        int nw;
        nw = (d == 2) ? 1 : 4;
        base = cyc;
        push_windows(d, 3);
        dq.push_back('{d, 3 + nw});
        for (int k = 0; k <= nw + 5; k++) begin
            start_v = 3'b000;
            start_v[d] = (k == 0);
            win_ready = 1'b1;
            if (k == 0) check("pad_en_c0", int'(pad_v[d]), 0);
            if (k == 1) begin
                check("pad_en_c1", int'(pad_v[d]), 1);
                check("busy_c1", int'(busy_v[d]), 1);
            end
            if (k == 2) begin
                check("pad_en_c2", int'(pad_v[d]), 0);
                check("valid_c2", int'(valid_v[d]), 0);
            end
            if (k == 3) check("valid_c3", int'(valid_v[d]), 1);
            if (k == nw + 3) check("busy_done", int'(busy_v[d]), 1);
            if (k == nw + 4) check("busy_after", int'(busy_v[d]), 0);
            step();
        end
        start_v = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) check_idle(d);
        reset = 1'b0;
        step();

        // nominal pass, SIZE=5 F=3
        full_pass(0);

        // backpressure in cycles 4-6
        base = cyc;
        wq.push_back('{0, 0, 0, 0, 3});
        wq.push_back('{0, 0, 3, 0, 7});
        wq.push_back('{0, 3, 0, 0, 8});
        wq.push_back('{0, 3, 3, 1, 9});
        dq.push_back('{0, 10});
        for (int k = 0; k <= 12; k++) begin
            start_v[0] = (k == 0);
            win_ready = !(k >= 4 && k <= 6);
            if (k == 6) begin
                check("hold_valid", int'(valid_v[0]), 1);
                check("hold_row", row_of(0), 0);
                check("hold_col", col_of(0), 3);
            end
            if (k == 11) check("bp_busy_after", int'(busy_v[0]), 0);
            step();
        end

        // start pulses during a pass are ignored
        begin
            int p0;
            p0 = pad_count0;
            base = cyc;
            push_windows(0, 3);
            dq.push_back('{0, 7});
            for (int k = 0; k <= 14; k++) begin
                start_v[0] = (k == 0 || k == 2 || k == 5 || k == 7);
                win_ready = 1'b1;
                if (k == 9) check("no_repass_busy9", int'(busy_v[0]), 0);
                if (k == 12) check("no_repass_busy12", int'(busy_v[0]), 0);
                step();
            end
            start_v = 3'b000;
            check("pad_en_pulses", pad_count0 - p0, 1);
        end

        // abort in SCAN after two accepts, then restart
        base = cyc;
        wq.push_back('{0, 0, 0, 0, 3});
        wq.push_back('{0, 0, 3, 0, 4});
        for (int k = 0; k <= 8; k++) begin
            start_v[0] = (k == 0);
            win_ready = (k != 5);
            abort = (k == 5);
            if (k == 6) begin
                check("abort_busy", int'(busy_v[0]), 0);
                check("abort_valid", int'(valid_v[0]), 0);
            end
            step();
        end
        abort = 1'b0;
        full_pass(0);

        // abort coinciding with the last acceptance: window consumed, no done
        base = cyc;
        push_windows(0, 3);
        for (int k = 0; k <= 9; k++) begin
            start_v[0] = (k == 0);
            win_ready = 1'b1;
            abort = (k == 6);
            if (k == 7) begin
                check("abort_last_busy", int'(busy_v[0]), 0);
                check("abort_last_done", int'(done_v[0]), 0);
            end
            step();
        end
        abort = 1'b0;
        start_v = 3'b000;

        // reset held two cycles mid-SCAN
        base = cyc;
        wq.push_back('{0, 0, 0, 0, 3});
        for (int k = 0; k <= 7; k++) begin
            start_v[0] = (k == 0);
            win_ready = (k < 4);
            reset = (k == 4 || k == 5);
            if (k == 5) check("reset_busy", int'(busy_v[0]), 0);
            if (k == 6) check_idle(0);
            step();
        end
        reset = 1'b0;
        full_pass(0);

        // exact fit and degenerate single window
        full_pass(1);
        full_pass(2);

        check("win_queue_empty", wq.size(), 0);
        check("done_queue_empty", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
